// File: rtl/sa_result_drain.sv
// Result drain for the systolic core: captures result vectors into two ping-pong
// slots and serializes their valid rows onto a single valid/ready word stream.
module sa_result_drain #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16,
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ROWS-1:0]    rvalid_in,
  input  logic [ROWS*DW-1:0] rdata_in,
  output logic               outread,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [RW-1:0]      out_row,
  output logic               out_last,
  output logic [CNTW-1:0]    vec_count,
  output logic               busy
);

  logic [1:0]      occ_q;
  logic [ROWS-1:0] mask_q [2];
  logic [DW-1:0]   data_q [2][ROWS];
  logic            wp_q, rp_q;
  logic            outread_q;
  logic [CNTW-1:0] cnt_q;

  logic [ROWS-1:0] head_mask;
  logic [ROWS-1:0] low_onehot;
  logic [RW-1:0]   head_row;
  logic            head_valid;
  logic            head_last;
  logic            accept;
  logic            capture;

  always_comb begin
    head_mask  = mask_q[rp_q];
    head_valid = occ_q[rp_q];
    // Isolate the lowest set mask bit; the remaining bits decide out_last.
    low_onehot = head_mask & (~head_mask + ROWS'(1));
    head_last  = ((head_mask & ~low_onehot) == '0);
    head_row   = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (head_mask[i]) head_row = RW'(i);
    end
  end

  assign accept  = head_valid & out_ready;
  // Capture looks only at registered state, so rvalid_in never reaches outread combinationally.
  assign capture = (|rvalid_in) & ~occ_q[wp_q] & ~outread_q;

  assign out_valid = head_valid;
  assign out_data  = head_valid ? data_q[rp_q][head_row] : '0;
  assign out_row   = head_valid ? head_row : '0;
  assign out_last  = head_valid & head_last;
  assign outread   = outread_q;
  assign vec_count = cnt_q;
  assign busy      = |occ_q;

  // Capture targets an empty slot and accept a full one, so they never share a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= '0;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      outread_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      outread_q <= capture;
      if (capture) begin
        occ_q[wp_q]  <= 1'b1;
        mask_q[wp_q] <= rvalid_in;
        wp_q         <= ~wp_q;
      end
      if (accept) begin
        mask_q[rp_q] <= head_mask & ~low_onehot;
        if (head_last) begin
          occ_q[rp_q] <= 1'b0;
          rp_q        <= ~rp_q;
          cnt_q       <= cnt_q + CNTW'(1);
        end
      end
    end
  end

  // Payload is qualified by the mask, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        data_q[wp_q][r] <= rdata_in[r*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Self-checking bench for sa_result_drain: FIFO-of-vectors reference model,
// directed test-plan scenarios and a randomized traffic phase.
module tb_sa_result_drain;
  localparam int ROWS = 8;
  localparam int DW   = 32;
  localparam int CNTW = 16;
  localparam int RW   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [ROWS-1:0]    rvalid_in;
  logic [ROWS*DW-1:0] rdata_in;
  logic               outread;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [RW-1:0]      out_row;
  logic               out_last;
  logic [CNTW-1:0]    vec_count;
  logic               busy;

  sa_result_drain #(.ROWS(ROWS), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .rvalid_in(rvalid_in), .rdata_in(rdata_in),
    .outread(outread), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .vec_count(vec_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of buffered vectors (at most two), remaining masks.
  logic [ROWS-1:0]    mq[$];
  logic [ROWS*DW-1:0] dq[$];
  logic               m_outread = 1'b0;
  logic [CNTW-1:0]    m_cnt = '0;
  int                 log_row[$];
  logic [DW-1:0]      log_data[$];
  bit                 log_last[$];
  int                 rd_pulses = 0;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic int lowest(logic [ROWS-1:0] m);
    for (int i = 0; i < ROWS; i++) if (m[i]) return i;
    return -1;
  endfunction

  // Compare process plus model advance, away from the active edge.
  always @(negedge clk) begin
    int r;
    bit ev, acc, cap;
    logic [ROWS-1:0] tmp;
    logic [DW-1:0] wd;
    ev = (mq.size() > 0);
    r = 0;
    wd = '0;
    if (ev) begin
      r  = lowest(mq[0]);
      wd = dq[0][r*DW +: DW];
    end
    check("outread", {63'd0, outread}, {63'd0, m_outread});
    check("out_valid", {63'd0, out_valid}, {63'd0, ev});
    check("busy", {63'd0, busy}, {63'd0, ev});
    check("vec_count", 64'(vec_count), 64'(m_cnt));
    if (ev) begin
      check("out_data", 64'(out_data), 64'(wd));
      check("out_row", 64'(out_row), 64'(r));
      check("out_last", {63'd0, out_last}, {63'd0, ((mq[0] >> (r + 1)) == 0)});
    end else begin
      check("idle_zero", {30'd0, out_data, out_row, out_last}, 64'd0);
    end
    if (outread) rd_pulses++;
    if (rst) begin
      mq.delete();
      dq.delete();
      m_outread = 1'b0;
      m_cnt = '0;
    end else begin
      acc = ev && out_ready;
      cap = (rvalid_in != 0) && (mq.size() < 2) && !m_outread;
      if (acc) begin
        log_row.push_back(r);
        log_data.push_back(wd);
        log_last.push_back((mq[0] >> (r + 1)) == 0);
        tmp = mq[0];
        tmp[r] = 1'b0;
        mq[0] = tmp;
        if (tmp == 0) begin
          void'(mq.pop_front());
          void'(dq.pop_front());
          m_cnt = m_cnt + 1'b1;
        end
      end
      if (cap) begin
        mq.push_back(rvalid_in);
        dq.push_back(rdata_in);
      end
      m_outread = cap;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [ROWS-1:0] m, input logic [ROWS*DW-1:0] d);
    int k;
    rvalid_in = m;
    rdata_in  = d;
    for (k = 0; k < 300; k++) begin
      tick();
      if (m_outread) break;
    end
    if (k == 300) begin
      n_chk++;
      $display("FAIL offer_timeout: outread got 0 required 1 at %0t", $time);
    end
    rvalid_in = '0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500; k++) begin
      if (mq.size() == 0 && !m_outread) break;
      tick();
    end
    if (k == 500) begin
      n_chk++;
      $display("FAIL idle_timeout: buffered %0d required 0", mq.size());
    end
  endtask

  function automatic logic [ROWS*DW-1:0] ramp(input int base);
    logic [ROWS*DW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  function automatic logic [ROWS*DW-1:0] rnd_vec();
    logic [ROWS*DW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  logic [ROWS*DW-1:0] vecs[$];

  initial begin
    rst = 1'b1;
    rvalid_in = 8'hFF;
    rdata_in = ramp(32'h50);
    out_ready = 1'b1;

    // 1: reset held with a vector offered, capture at first edge after release
    repeat (3) begin
      tick();
      check("t1_rst_outread", {63'd0, outread}, 64'd0);
      check("t1_rst_busy", {63'd0, busy}, 64'd0);
    end
    rst = 1'b0;
    tick();
    check("t1_first_capture", {63'd0, outread}, 64'd1);
    rvalid_in = '0;
    wait_idle();

    // 2: single full vector
    log_row.delete(); log_data.delete(); log_last.delete();
    rd_pulses = 0;
    offer(8'hFF, ramp(100));
    wait_idle();
    tick();
    check("t2_beats", 64'(log_row.size()), 64'd8);
    for (int i = 0; i < log_row.size(); i++) begin
      check("t2_row", 64'(log_row[i]), 64'(i));
      check("t2_data", 64'(log_data[i]), 64'(100 + i));
      check("t2_last", {63'd0, log_last[i]}, {63'd0, i == 7});
    end
    check("t2_pulses", 64'(rd_pulses), 64'd1);
    check("t2_vec_count", 64'(vec_count), 64'd2);
    check("t2_busy", {63'd0, busy}, 64'd0);

    // 3: sparse mask
    log_row.delete(); log_data.delete(); log_last.delete();
    offer(8'b1000_0101, rnd_vec());
    wait_idle();
    check("t3_beats", 64'(log_row.size()), 64'd3);
    if (log_row.size() == 3) begin
      check("t3_rows", {40'd0, 8'(log_row[0]), 8'(log_row[1]), 8'(log_row[2])},
            {40'd0, 8'd0, 8'd2, 8'd7});
      check("t3_lasts", {61'd0, log_last[0], log_last[1], log_last[2]}, 64'b001);
    end
    check("t3_vec_count", 64'(vec_count), 64'd3);

    // 4: backpressure with three vectors offered
    log_row.delete(); log_data.delete(); log_last.delete();
    vecs.delete();
    for (int v = 0; v < 3; v++) vecs.push_back(ramp(1000 * (v + 1)));
    out_ready = 1'b0;
    rd_pulses = 0;
    fork
      begin
        repeat (20) tick();
        check("t4_pulses_blocked", 64'(rd_pulses), 64'd2);
        out_ready = 1'b1;
      end
      begin
        for (int v = 0; v < 3; v++) offer(8'hFF, vecs[v]);
      end
    join
    wait_idle();
    check("t4_beats", 64'(log_data.size()), 64'd24);
    for (int i = 0; i < log_data.size() && i < 24; i++)
      check("t4_order", 64'(log_data[i]), 64'(1000 * (i / 8 + 1) + i % 8));
    check("t4_vec_count", 64'(vec_count), 64'd6);

    // 5: reset mid-drain
    log_row.delete(); log_data.delete(); log_last.delete();
    offer(8'hFF, ramp(200));
    for (int k = 0; k < 50 && log_row.size() < 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t5_beats", 64'(log_row.size()), 64'd3);
    check("t5_vec_count", 64'(vec_count), 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_valid", {63'd0, out_valid}, 64'd0);

    // 6: streaming, rvalid held high, data changes on each acknowledge
    log_row.delete(); log_data.delete(); log_last.delete();
    vecs.delete();
    out_ready = 1'b1;
    rvalid_in = 8'hFF;
    rdata_in = rnd_vec();
    for (int v = 0; v < 12; v++) begin
      int k;
      for (k = 0; k < 100; k++) begin
        tick();
        if (m_outread) break;
      end
      if (k == 100) begin
        n_chk++;
        $display("FAIL t6_ack_timeout: outread got 0 required 1");
      end
      vecs.push_back(rdata_in);
      rdata_in = rnd_vec();
    end
    rvalid_in = '0;
    wait_idle();
    check("t6_beats", 64'(log_data.size()), 64'd96);
    for (int i = 0; i < log_data.size() && i < 96; i++)
      check("t6_data", 64'(log_data[i]), 64'(vecs[i / 8][(i % 8)*DW +: DW]));
    begin
      int nl = 0;
      foreach (log_last[i]) if (log_last[i]) nl++;
      check("t6_lasts", 64'(nl), 64'd12);
    end
    check("t6_vec_count", 64'(vec_count), 64'd12);

    // Random traffic: random masks, data and backpressure; the compare process checks each cycle
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (m_outread) rvalid_in = '0;
      else if (rvalid_in == 0 && $urandom_range(0, 2) == 0) begin
        rvalid_in = ROWS'($urandom);
        rdata_in = rnd_vec();
      end
      tick();
    end
    rvalid_in = '0;
    out_ready = 1'b1;
    wait_idle();
    tick();
    check("rnd_busy", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
